// File: rtl/mk_top_pkg.sv
// mk_top_pkg: shared opcodes, FSM states, request layout and ALU op codes for the mk_top core.
package mk_top_pkg;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6f;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_OPIMM  = 7'h13;
    localparam logic [6:0] OP_OP     = 7'h33;
    localparam int ADDR_LSB = 33;
    localparam int WR_BIT   = 32;
    typedef enum logic [1:0] {FETCH, REQ, WAIT, EXEC} state_t;
    // Encoded as {alt, funct3} so the decoder can pass instruction bits straight through.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000, ALU_SLL = 4'b0001, ALU_SLT = 4'b0010, ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100, ALU_SRL = 4'b0101, ALU_OR  = 4'b0110, ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000, ALU_SRA = 4'b1101
    } alu_op_t;
endpackage

// File: rtl/mk_top_alu.sv
// mk_top_alu: combinational RV32I integer ALU with branch-compare flags.
import mk_top_pkg::*;

module mk_top_alu (
    input  alu_op_t     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y,
    output logic        eq,
    output logic        lt,
    output logic        ltu
);
    assign eq  = a == b;
    assign lt  = $signed(a) < $signed(b);
    assign ltu = a < b;
    always_comb begin
        case (op)
            ALU_SUB:  y = a - b;
            ALU_SLL:  y = a << b[4:0];
            ALU_SLT:  y = {31'b0, lt};
            ALU_SLTU: y = {31'b0, ltu};
            ALU_XOR:  y = a ^ b;
            ALU_SRL:  y = a >> b[4:0];
            ALU_SRA:  y = $signed(a) >>> b[4:0];
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            default:  y = a + b;
        endcase
    end
endmodule

// File: rtl/mk_top.sv
// mk_top: multi-cycle RV32I core sharing one get/put memory port for fetch, load and store.
import mk_top_pkg::*;

module mk_top #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        EN_obtain_rq_get,
    output logic [64:0] obtain_rq_get,
    output logic        RDY_obtain_rq_get,
    input  logic [31:0] send_rs_put,
    input  logic        EN_send_rs_put,
    output logic        RDY_send_rs_put
);
    state_t      state, state_nx;
    logic [31:0] pc, instr;
    logic [31:0] regs [32];
    logic [64:0] req;
    logic        data_rq;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, rv1, rv2, pc4, addr, alu_y, wb_val, pc_nx;
    logic        eq, lt, ltu, taken, wb_en, mem, consume;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign rv1    = regs[rs1];
    assign rv2    = regs[rs2];
    assign pc4    = pc + 32'd4;
    assign addr   = rv1 + (opcode == OP_STORE ? imm_s : imm_i);
    assign mem    = opcode == OP_LOAD || opcode == OP_STORE;
    assign consume = (state == REQ && EN_obtain_rq_get && EN_send_rs_put) || (state == WAIT && EN_send_rs_put);
    assign obtain_rq_get     = req;
    assign RDY_obtain_rq_get = state == REQ;
    assign RDY_send_rs_put   = state == REQ || state == WAIT;
    mk_top_alu u_alu (
        .op  (alu_op_t'({instr[30] && (opcode == OP_OP || f3 == 3'b101), f3})),
        .a   (rv1),
        .b   (opcode == OP_OP || opcode == OP_BRANCH ? rv2 : imm_i),
        .y   (alu_y),
        .eq  (eq),
        .lt  (lt),
        .ltu (ltu)
    );
    assign taken = f3[2:1] == 2'b00 ? eq ^ f3[0] :
                   f3[2:1] == 2'b10 ? lt ^ f3[0] :
                   f3[2:1] == 2'b11 ? ltu ^ f3[0] : 1'b0;
    always_comb begin
        wb_en  = 1'b0;
        wb_val = alu_y;
        pc_nx  = pc4;
        case (opcode)
            OP_LUI:    begin wb_en = 1'b1; wb_val = imm_u; end
            OP_AUIPC:  begin wb_en = 1'b1; wb_val = pc + imm_u; end
            OP_JAL:    begin wb_en = 1'b1; wb_val = pc4; pc_nx = pc + imm_j; end
            OP_JALR:   begin wb_en = 1'b1; wb_val = pc4; pc_nx = addr & ~32'h1; end
            OP_BRANCH: pc_nx = taken ? pc + imm_b : pc4;
            OP_OPIMM,
            OP_OP:     wb_en = 1'b1;
            default:   ;
        endcase
    end
    always_comb begin
        state_nx = state;
        case (state)
            FETCH: state_nx = REQ;
            REQ:   state_nx = !EN_obtain_rq_get ? REQ : !EN_send_rs_put ? WAIT : data_rq ? FETCH : EXEC;
            WAIT:  state_nx = !EN_send_rs_put ? WAIT : data_rq ? FETCH : EXEC;
            EXEC:  state_nx = mem ? REQ : FETCH;
        endcase
    end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            instr   <= '0;
            req     <= '0;
            data_rq <= 1'b0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            state <= state_nx;
            if (state == FETCH) begin
                req     <= {pc, 1'b0, 32'h0};
                data_rq <= 1'b0;
            end
            // A data response finishes a load/store; a fetch response starts execution.
            if (consume) begin
                if (!data_rq) instr <= send_rs_put;
                else begin
                    if (!req[WR_BIT] && rd != 5'd0) regs[rd] <= send_rs_put;
                    pc <= pc4;
                end
            end
            if (state == EXEC) begin
                if (mem) begin
                    req     <= {addr, opcode == OP_STORE, opcode == OP_STORE ? rv2 : 32'h0};
                    data_rq <= 1'b1;
                end else begin
                    if (wb_en && rd != 5'd0) regs[rd] <= wb_val;
                    pc <= pc_nx;
                end
            end
        end
    end
endmodule

// File: tb/tb_mk_top.sv
// tb_mk_top: directed program run against mk_top with a scoreboard of expected memory requests.
module tb_mk_top;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        EN_obtain_rq_get = 1'b0;
    logic [64:0] obtain_rq_get;
    logic        RDY_obtain_rq_get;
    logic [31:0] send_rs_put = '0;
    logic        EN_send_rs_put = 1'b0;
    logic        RDY_send_rs_put;
    logic [64:0] sb [$];
    int passed = 0;
    int total = 0;

    mk_top dut (
        .CLK               (CLK),
        .RST_N             (RST_N),
        .EN_obtain_rq_get  (EN_obtain_rq_get),
        .obtain_rq_get     (obtain_rq_get),
        .RDY_obtain_rq_get (RDY_obtain_rq_get),
        .send_rs_put       (send_rs_put),
        .EN_send_rs_put    (EN_send_rs_put),
        .RDY_send_rs_put   (RDY_send_rs_put)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wait_rdy();
        int n = 0;
        while (RDY_obtain_rq_get !== 1'b1 && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        check("rdy_timeout", {64'b0, RDY_obtain_rq_get}, 65'd1);
    endtask

    // Expect request exp, answer with rsp after lat cycles (0 = same cycle as the get).
    task automatic serve(input string tag, input logic [64:0] exp, input logic [31:0] rsp, input int lat);
        logic [64:0] e;
        sb.push_back(exp);
        wait_rdy();
        e = sb.pop_front();
        check(tag, obtain_rq_get, e);
        EN_obtain_rq_get = 1'b1;
        EN_send_rs_put = (lat == 0);
        send_rs_put = rsp;
        @(posedge CLK); #1;
        EN_obtain_rq_get = 1'b0;
        EN_send_rs_put = 1'b0;
        if (lat == 0) begin
            check({tag, "_nowait"}, {63'b0, RDY_send_rs_put, RDY_obtain_rq_get}, 65'd0);
        end else begin
            repeat (lat - 1) begin @(posedge CLK); #1; end
            check({tag, "_wait"}, {63'b0, RDY_send_rs_put, RDY_obtain_rq_get}, 65'b10);
            EN_send_rs_put = 1'b1;
            @(posedge CLK); #1;
            EN_send_rs_put = 1'b0;
        end
    endtask

    function automatic logic [64:0] fetch(input logic [31:0] a);
        return {a, 1'b0, 32'h0};
    endfunction

    task automatic do_reset();
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
    endtask

    initial begin
        @(posedge CLK); #1;
        check("reset_out", {RDY_obtain_rq_get, RDY_send_rs_put, obtain_rq_get}, 67'd0);
        RST_N = 1'b1;
        wait_rdy();
        // Request must hold; a stray put while the get is withheld is ignored.
        for (int i = 0; i < 5; i++) begin
            check("hold_rq", obtain_rq_get, fetch(32'h0));
            check("hold_rdy", {63'b0, RDY_obtain_rq_get, RDY_send_rs_put}, 65'b11);
            EN_send_rs_put = (i == 2);
            send_rs_put = 32'h0bad_0bad;
            @(posedge CLK); #1;
            EN_send_rs_put = 1'b0;
        end
        serve("f0", fetch(32'h0), 32'h00500093, 1);
        serve("f4", fetch(32'h4), 32'h10012137, 1);
        serve("f8", fetch(32'h8), 32'h00112623, 1);
        serve("sw_x1", {32'h1001200c, 1'b1, 32'h5}, 32'h0, 1);
        serve("fc", fetch(32'hc), 32'h00002183, 1);
        serve("lw_x3", {32'h0, 1'b0, 32'h0}, 32'hdeadbeef, 2);
        serve("f10", fetch(32'h10), 32'h04302023, 0);
        serve("sw_x3", {32'h40, 1'b1, 32'hdeadbeef}, 32'h0, 0);
        serve("f14", fetch(32'h14), 32'h00700013, 0);
        serve("f18", fetch(32'h18), 32'h04002023, 1);
        serve("sw_x0", {32'h40, 1'b1, 32'h0}, 32'h0, 1);
        do_reset();
        serve("r_f0", fetch(32'h0), 32'h00000013, 0);
        serve("r_f4", fetch(32'h4), 32'hffd00293, 1);
        serve("r_f8", fetch(32'h8), 32'hfe000ee3, 1);
        serve("beq_f4", fetch(32'h4), 32'h4012d313, 1);
        serve("r_f8b", fetch(32'h8), 32'h00602023, 1);
        serve("sw_srai", {32'h0, 1'b1, 32'hfffffffe}, 32'h0, 1);
        serve("r_fc", fetch(32'hc), 32'h405303b3, 1);
        serve("r_f10", fetch(32'h10), 32'h00702223, 1);
        serve("sw_sub", {32'h4, 1'b1, 32'h1}, 32'h0, 1);
        wait_rdy();
        check("pre_wait_rq", obtain_rq_get, fetch(32'h14));
        EN_obtain_rq_get = 1'b1;
        @(posedge CLK); #1;
        EN_obtain_rq_get = 1'b0;
        check("in_wait", {63'b0, RDY_send_rs_put, RDY_obtain_rq_get}, 65'b10);
        RST_N = 1'b0;
        #1;
        check("async_rst", {RDY_obtain_rq_get, RDY_send_rs_put, obtain_rq_get}, 67'd0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        serve("post_rst_f0", fetch(32'h0), 32'h00000013, 1);
        serve("post_rst_f4", fetch(32'h4), 32'h00000013, 1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
